// File: rtl/ibex_aes_key_loader.sv
// AES key loader: stages a 128-bit key through a 32-bit write port and swaps it in on COMMIT,
// never disturbing the active key while the secure ALU is busy. Optional lock via IBEX_AES_KEY_LOCK_EN.
module ibex_aes_key_loader #(
   parameter bit          ClearOnError  = 1'b1,
   parameter int unsigned MaxPendCycles = 64
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          wr_valid_i,
   output logic          wr_ready_o,
   input  logic [2:0]    wr_addr_i,
   input  logic [31:0]   wr_data_i,
   input  logic          crypto_busy_i,
   input  logic          crypto_error_i,
   output logic [127:0]  aes_key_o,
   output logic          aes_key_valid_o,
   output logic [4:0]    status_o
);

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      PENDING
   } state_e;

   localparam logic [7:0] PendLast = 8'(MaxPendCycles - 1);

   state_e        state_q, state_d;
   logic [127:0]  stage_q, stage_d;
   logic [127:0]  key_q, key_d;
   logic [3:0]    mask_q, mask_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          stage_full;
   logic          lock_bit;
   logic          err_set, err_clr, swap;

`ifdef IBEX_AES_KEY_LOCK_EN
   logic          locked_q, locked_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         locked_q <= 1'b0;
      end else begin
         locked_q <= locked_d;
      end
   end

   assign lock_bit = locked_q;
`else
   assign lock_bit = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         stage_q <= '0;
         key_q   <= '0;
         mask_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         key_q   <= key_d;
         mask_q  <= mask_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign stage_full = &mask_q;

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      key_d   = key_q;
      mask_d  = mask_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      err_set = 1'b0;
      err_clr = 1'b0;
      swap    = 1'b0;
`ifdef IBEX_AES_KEY_LOCK_EN
      locked_d = locked_q;
`endif

      if (state_q == PENDING) begin
         // An abort falls back to whatever the key validity says, since an error may have dropped it
         if (!crypto_busy_i) begin
            swap = 1'b1;
         end else if (cnt_q == PendLast) begin
            err_set = 1'b1;
            state_d = valid_q ? ACTIVE : IDLE;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end else if (wr_valid_i) begin
         if (!wr_addr_i[2]) begin
            if (lock_bit) begin
               err_set = 1'b1;
            end else begin
               stage_d[{wr_addr_i[1:0], 5'b00000} +: 32] = wr_data_i;
               mask_d[wr_addr_i[1:0]] = 1'b1;
            end
         end else if (wr_addr_i == 3'd4) begin
            if (wr_data_i[1]) begin
               if (lock_bit) begin
                  err_set = 1'b1;
               end else begin
                  key_d   = '0;
                  valid_d = 1'b0;
                  stage_d = '0;
                  mask_d  = '0;
                  state_d = IDLE;
               end
            end else if (wr_data_i[0] && !lock_bit) begin
               if (!stage_full) begin
                  err_set = 1'b1;
               end else if (crypto_busy_i) begin
                  state_d = PENDING;
                  cnt_d   = '0;
               end else begin
                  swap = 1'b1;
               end
            end
            err_clr = wr_data_i[2];
`ifdef IBEX_AES_KEY_LOCK_EN
            if (wr_data_i[3]) begin
               locked_d = 1'b1;
            end
`endif
         end else begin
            err_set = 1'b1;
         end
      end

      if (swap) begin
         key_d   = stage_q;
         valid_d = 1'b1;
         stage_d = '0;
         mask_d  = '0;
         state_d = ACTIVE;
      end

      // A same-cycle swap beats invalidation; a pending commit survives the invalidation
      if (crypto_error_i) begin
         err_set = 1'b1;
         if (ClearOnError && valid_q && !swap) begin
            key_d   = '0;
            valid_d = 1'b0;
            if (state_d != PENDING) begin
               state_d = IDLE;
            end
         end
      end

      err_d = err_set | (err_q & ~err_clr);
   end

   assign wr_ready_o      = (state_q != PENDING);
   assign aes_key_o       = key_q;
   assign aes_key_valid_o = valid_q;
   assign status_o        = {lock_bit, err_q, (state_q == PENDING), stage_full, valid_q};

endmodule

// File: tb/tb_ibex_aes_key_loader.sv
// Self-checking bench for ibex_aes_key_loader: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the key loader.
module tb_ibex_aes_key_loader;

   localparam int MAX_PEND = 64;
   localparam bit CLEAR_ON_ERR = 1'b1;
`ifdef IBEX_AES_KEY_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   localparam logic [127:0] KEY_A = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
   localparam logic [127:0] KEY_B = 128'h44444444_33333333_22222222_11111111;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [2:0]    wr_addr = '0;
   logic [31:0]   wr_data = '0;
   logic          busy = 1'b0;
   logic          err_in = 1'b0;
   logic [127:0]  aes_key;
   logic          aes_valid;
   logic [4:0]    status;

   // Behavioural model state
   logic [31:0]   m_word [4];
   logic [3:0]    m_have;
   logic [127:0]  m_key;
   logic          m_valid, m_err, m_pending, m_locked;
   int            m_wait;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   ibex_aes_key_loader #(
      .ClearOnError (CLEAR_ON_ERR),
      .MaxPendCycles(MAX_PEND)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .wr_valid_i     (wr_valid),
      .wr_ready_o     (wr_ready),
      .wr_addr_i      (wr_addr),
      .wr_data_i      (wr_data),
      .crypto_busy_i  (busy),
      .crypto_error_i (err_in),
      .aes_key_o      (aes_key),
      .aes_key_valid_o(aes_valid),
      .status_o       (status)
   );

   task automatic modelSwap();
      m_key     = {m_word[3], m_word[2], m_word[1], m_word[0]};
      m_valid   = 1'b1;
      m_word    = '{default: '0};
      m_have    = '0;
      m_pending = 1'b0;
   endtask

   task automatic modelStep();
      bit errset, errclr, swapped, was_valid;
      if (rst) begin
         m_word    = '{default: '0};
         m_have    = '0;
         m_key     = '0;
         m_valid   = 1'b0;
         m_err     = 1'b0;
         m_pending = 1'b0;
         m_wait    = 0;
         m_locked  = 1'b0;
         return;
      end
      errset    = 1'b0;
      errclr    = 1'b0;
      swapped   = 1'b0;
      was_valid = m_valid;
      if (m_pending) begin
         if (!busy) begin
            modelSwap();
            swapped = 1'b1;
         end else begin
            m_wait++;
            if (m_wait >= MAX_PEND) begin
               m_pending = 1'b0;
               errset    = 1'b1;
            end
         end
      end else if (wr_valid) begin
         if (wr_addr < 3'd4) begin
            if (m_locked) errset = 1'b1;
            else begin
               m_word[wr_addr[1:0]] = wr_data;
               m_have[wr_addr[1:0]] = 1'b1;
            end
         end else if (wr_addr == 3'd4) begin
            if (wr_data[1]) begin
               if (m_locked) errset = 1'b1;
               else begin
                  m_key   = '0;
                  m_valid = 1'b0;
                  m_word  = '{default: '0};
                  m_have  = '0;
               end
            end else if (wr_data[0] && !m_locked) begin
               if (m_have != 4'hF) errset = 1'b1;
               else if (busy) begin
                  m_pending = 1'b1;
                  m_wait    = 0;
               end else begin
                  modelSwap();
                  swapped = 1'b1;
               end
            end
            if (wr_data[2]) errclr = 1'b1;
            if (LOCK_EN && wr_data[3]) m_locked = 1'b1;
         end else begin
            errset = 1'b1;
         end
      end
      if (err_in) begin
         errset = 1'b1;
         if (CLEAR_ON_ERR && was_valid && !swapped) begin
            m_key   = '0;
            m_valid = 1'b0;
         end
      end
      if (errset) m_err = 1'b1;
      else if (errclr) m_err = 1'b0;
   endtask

   task automatic check1(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      check1({tag, "_key"}, aes_key, m_key);
      check1({tag, "_valid"}, 128'(aes_valid), 128'(m_valid));
      check1({tag, "_ready"}, 128'(wr_ready), 128'(!m_pending));
      check1({tag, "_status"}, 128'(status),
             128'({m_locked, m_err, m_pending, &m_have, m_valid}));
   endtask

   task automatic applyStimulus(input bit r, input bit v, input logic [2:0] a,
                                input logic [31:0] d, input bit b, input bit e,
                                input string tag);
      rst      = r;
      wr_valid = v;
      wr_addr  = a;
      wr_data  = d;
      busy     = b;
      err_in   = e;
      @(posedge clk);
      modelStep();
      #1;
      checkOutput(tag);
   endtask

   task automatic loadKey(input logic [127:0] k, input bit b);
      for (int w = 0; w < 4; w++) begin
         applyStimulus(0, 1, 3'(w), k[32*w +: 32], b, 0, "load");
      end
   endtask

   initial begin
      int n;
      bit b;
      bit r, v, e;
      logic [2:0] a;
      logic [31:0] d;
      int sel;

      applyStimulus(1, 0, 0, 0, 0, 0, "reset");
      applyStimulus(1, 0, 0, 0, 0, 0, "reset");
      check1("reset_status_const", 128'(status), 128'(5'b00000));
      check1("reset_ready_const", 128'(wr_ready), 128'(1'b1));
      applyStimulus(0, 0, 0, 0, 0, 0, "idle");

      // Basic load and commit
      loadKey(KEY_A, 0);
      applyStimulus(0, 1, 3'd4, 32'h1, 0, 0, "commit");
      check1("commit_key_const", aes_key, KEY_A);
      check1("commit_status_const", 128'(status), 128'(5'b00001));

      // Partial stage commit is rejected
      for (int w = 0; w < 3; w++) applyStimulus(0, 1, 3'(w), KEY_B[32*w +: 32], 0, 0, "partial");
      applyStimulus(0, 1, 3'd4, 32'h1, 0, 0, "reject");
      check1("reject_key_const", aes_key, KEY_A);
      check1("reject_err_const", 128'(status[3]), 128'(1'b1));
      check1("reject_full_const", 128'(status[1]), 128'(1'b0));
      applyStimulus(0, 1, 3'd4, 32'h4, 0, 0, "errclr");

      // Commit while busy waits, then swaps once busy drops
      applyStimulus(0, 1, 3'd3, KEY_B[127:96], 1, 0, "word3");
      applyStimulus(0, 1, 3'd4, 32'h1, 1, 0, "pend_commit");
      check1("pend_bit_const", 128'(status[2]), 128'(1'b1));
      check1("pend_ready_const", 128'(wr_ready), 128'(1'b0));
      for (int c = 0; c < 9; c++) applyStimulus(0, 0, 0, 0, 1, 0, "pend_hold");
      check1("pend_hold_key_const", aes_key, KEY_A);
      applyStimulus(0, 0, 0, 0, 0, 0, "pend_swap");
      check1("pend_swap_key_const", aes_key, KEY_B);
      check1("pend_swap_ready_const", 128'(wr_ready), 128'(1'b1));

      // Busy never drops: the commit aborts after MAX_PEND cycles
      loadKey(KEY_A, 1);
      applyStimulus(0, 1, 3'd4, 32'h1, 1, 0, "abort_commit");
      n = 0;
      while (status[2] === 1'b1 && n < 100) begin
         applyStimulus(0, 0, 0, 0, 1, 0, "abort_wait");
         n++;
      end
      check1("abort_cycles", 128'(n), 128'(MAX_PEND));
      check1("abort_key_const", aes_key, KEY_B);
      check1("abort_status_const", 128'(status[3:0]), 128'(4'b1011));
      applyStimulus(0, 1, 3'd4, 32'h4, 0, 0, "abort_errclr");

      // Error pulse invalidates the active key
      applyStimulus(0, 0, 0, 0, 0, 1, "error");
      check1("error_valid_const", 128'(aes_valid), 128'(1'b0));
      check1("error_key_const", aes_key, 128'h0);
      check1("error_err_const", 128'(status[3]), 128'(1'b1));
      applyStimulus(0, 1, 3'd4, 32'h4, 0, 0, "error_clr");
      check1("error_clr_const", 128'(status[3]), 128'(1'b0));

      // Randomized traffic against the model
      b = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         r = ($urandom_range(0, 299) == 0);
         v = ($urandom_range(0, 2) != 0);
         sel = $urandom_range(0, 15);
         d = $urandom;
         if (sel < 8) a = 3'(sel % 4);
         else if (sel < 15) begin
            a = 3'd4;
            d[3] = 1'b0;
            d[0] = ($urandom_range(0, 1) == 1);
            d[1] = ($urandom_range(0, 7) == 0);
            d[2] = ($urandom_range(0, 3) == 0);
         end else a = 3'($urandom_range(5, 7));
         if ($urandom_range(0, 5) == 0) b = ~b;
         e = !m_pending && ($urandom_range(0, 29) == 0);
         applyStimulus(r, v, a, d, b, e, "rand");
      end

`ifdef IBEX_AES_KEY_LOCK_EN
      applyStimulus(1, 0, 0, 0, 0, 0, "lock_reset");
      loadKey(KEY_A, 0);
      applyStimulus(0, 1, 3'd4, 32'h1, 0, 0, "lock_commit");
      applyStimulus(0, 1, 3'd4, 32'h8, 0, 0, "lock_set");
      applyStimulus(0, 1, 3'd4, 32'h2, 0, 0, "lock_clear");
      check1("lock_key_const", aes_key, KEY_A);
      check1("lock_bits_const", 128'(status[4:3]), 128'(2'b11));
      applyStimulus(1, 0, 0, 0, 0, 0, "lock_rst");
      check1("lock_rst_const", 128'(status[4]), 128'(1'b0));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
